// File: rtl/ball_ctrl.sv
// Ball motion and pixel generation feeding the frame renderer.
// Ports: clk, reset (async, active-low), scan x/y, clk_1ms tick source,
// game_state, paddle tops in; ball_on, rgb_ball, point_p1/point_p2 out.
module ball_ctrl #(
    parameter int          H_ACTIVE       = 640,
    parameter int          V_ACTIVE       = 480,
    parameter int          BALL_SIZE      = 8,
    parameter int          PADDLE1_X      = 32,
    parameter int          PADDLE2_X      = 600,
    parameter int          PADDLE_W       = 8,
    parameter int          PADDLE_H       = 64,
    parameter int          SPEED          = 2,
    parameter int          TICKS_PER_STEP = 5,
    parameter int          SERVE_STEPS    = 50,
    parameter logic [23:0] BALL_COLOR     = 24'hFFFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        clk_1ms,
    input  logic [1:0]  game_state,
    input  logic [9:0]  paddle1_y,
    input  logic [9:0]  paddle2_y,
    output logic        ball_on,
    output logic [23:0] rgb_ball,
    output logic        point_p1,
    output logic        point_p2
);

    localparam int TK_W = $clog2(TICKS_PER_STEP + 1);
    localparam int SC_W = $clog2(SERVE_STEPS + 1);

    localparam logic [9:0]  C_X0  = 10'(H_ACTIVE / 2 - BALL_SIZE / 2);
    localparam logic [9:0]  C_Y0  = 10'(V_ACTIVE / 2 - BALL_SIZE / 2);
    localparam logic [9:0]  C_SP  = 10'(SPEED);
    localparam logic [9:0]  C_LF  = 10'(PADDLE1_X + PADDLE_W);
    localparam logic [9:0]  C_RX  = 10'(PADDLE2_X - BALL_SIZE);
    localparam logic [9:0]  C_BY  = 10'(V_ACTIVE - BALL_SIZE);
    localparam logic [10:0] W_BS  = 11'(BALL_SIZE);
    localparam logic [10:0] W_SP  = 11'(SPEED);
    localparam logic [10:0] W_LF  = 11'(PADDLE1_X + PADDLE_W);
    localparam logic [10:0] W_P2  = 11'(PADDLE2_X);
    localparam logic [10:0] W_PH  = 11'(PADDLE_H);
    localparam logic [10:0] W_H   = 11'(H_ACTIVE);
    localparam logic [10:0] W_V   = 11'(V_ACTIVE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SERVE,
        S_MOVE
    } state_t;

    state_t          r_state;
    logic [9:0]      r_ball_x;
    logic [9:0]      r_ball_y;
    logic            r_dx;      // 1 = right
    logic            r_dy;      // 1 = down
    logic [SC_W-1:0] r_serve_cnt;
    logic [TK_W-1:0] r_tick_cnt;
    logic            r_sync1;
    logic            r_sync2;
    logic            r_prev;
    logic            r_point_p1;
    logic            r_point_p2;

    logic            w_play;
    logic            w_edge;
    logic            w_step;
    logic [10:0]     w_bx;
    logic [10:0]     w_by;
    logic [10:0]     w_sx;
    logic [10:0]     w_sy;
    logic            w_ov1;
    logic            w_ov2;
    logic            w_hit_l;
    logic            w_hit_r;
    logic            w_miss_l;
    logic            w_miss_r;
    logic            w_top;
    logic            w_bot;
    logic [9:0]      w_nx;
    logic [9:0]      w_ny;
    logic            w_ndx;
    logic            w_ndy;

    assign w_play = (game_state == 2'b01);
    assign w_bx   = {1'b0, r_ball_x};
    assign w_by   = {1'b0, r_ball_y};
    assign w_sx   = {1'b0, x};
    assign w_sy   = {1'b0, y};

    assign ball_on  = (w_sx >= w_bx) && (w_sx < w_bx + W_BS) &&
                      (w_sy >= w_by) && (w_sy < w_by + W_BS);
    assign rgb_ball = BALL_COLOR;
    assign point_p1 = r_point_p1;
    assign point_p2 = r_point_p2;

    // Tick synchroniser and step divider
    assign w_edge = r_sync2 & ~r_prev;
    assign w_step = w_edge && (r_state != S_IDLE) &&
                    (r_tick_cnt == TK_W'(TICKS_PER_STEP - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_prev     <= 1'b0;
            r_tick_cnt <= '0;
        end else begin
            r_sync1 <= clk_1ms;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            if (r_state == S_IDLE) begin
                r_tick_cnt <= '0;
            end else if (w_edge) begin
                if (r_tick_cnt == TK_W'(TICKS_PER_STEP - 1))
                    r_tick_cnt <= '0;
                else
                    r_tick_cnt <= r_tick_cnt + 1'b1;
            end
        end
    end

    // Bounce / miss detection on the current position
    assign w_ov1 = (w_by + W_BS > {1'b0, paddle1_y}) &&
                   (w_by < {1'b0, paddle1_y} + W_PH);
    assign w_ov2 = (w_by + W_BS > {1'b0, paddle2_y}) &&
                   (w_by < {1'b0, paddle2_y} + W_PH);

    assign w_hit_l  = !r_dx && (w_bx > W_LF) &&
                      (w_bx <= W_LF + W_SP) && w_ov1;
    assign w_hit_r  = r_dx && (w_bx + W_BS < W_P2) &&
                      (w_bx + W_BS + W_SP >= W_P2) && w_ov2;
    assign w_miss_l = !r_dx && !w_hit_l && (w_bx < W_SP);
    assign w_miss_r = r_dx && !w_hit_r && (w_bx + W_BS + W_SP > W_H);
    assign w_top    = !r_dy && (w_by < W_SP);
    assign w_bot    = r_dy && (w_by + W_BS + W_SP > W_V);

    always_comb begin
        w_nx  = r_ball_x;
        w_ndx = r_dx;
        w_ny  = r_ball_y;
        w_ndy = r_dy;
        if (w_hit_l) begin
            w_nx  = C_LF;
            w_ndx = 1'b1;
        end else if (w_hit_r) begin
            w_nx  = C_RX;
            w_ndx = 1'b0;
        end else if (r_dx) begin
            w_nx = r_ball_x + C_SP;
        end else begin
            w_nx = r_ball_x - C_SP;
        end
        if (w_top) begin
            w_ny  = '0;
            w_ndy = 1'b1;
        end else if (w_bot) begin
            w_ny  = C_BY;
            w_ndy = 1'b0;
        end else if (r_dy) begin
            w_ny = r_ball_y + C_SP;
        end else begin
            w_ny = r_ball_y - C_SP;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_ball_x    <= C_X0;
            r_ball_y    <= C_Y0;
            r_dx        <= 1'b1;
            r_dy        <= 1'b1;
            r_serve_cnt <= '0;
            r_point_p1  <= 1'b0;
            r_point_p2  <= 1'b0;
        end else begin
            r_point_p1 <= 1'b0;
            r_point_p2 <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_ball_x    <= C_X0;
                    r_ball_y    <= C_Y0;
                    r_serve_cnt <= '0;
                    if (w_play)
                        r_state <= S_SERVE;
                end
                S_SERVE: begin
                    if (!w_play) begin
                        r_state <= S_IDLE;
                    end else if (w_step) begin
                        if (r_serve_cnt == SC_W'(SERVE_STEPS - 1)) begin
                            r_serve_cnt <= '0;
                            r_state     <= S_MOVE;
                        end else begin
                            r_serve_cnt <= r_serve_cnt + 1'b1;
                        end
                    end
                end
                S_MOVE: begin
                    if (!w_play) begin
                        r_state  <= S_IDLE;
                        r_ball_x <= C_X0;
                        r_ball_y <= C_Y0;
                    end else if (w_step) begin
                        r_dy <= w_ndy;
                        // A miss recentres and serves toward the conceding side
                        if (w_miss_l || w_miss_r) begin
                            r_point_p2  <= w_miss_l;
                            r_point_p1  <= w_miss_r;
                            r_ball_x    <= C_X0;
                            r_ball_y    <= C_Y0;
                            r_dx        <= w_miss_r;
                            r_serve_cnt <= '0;
                            r_state     <= S_SERVE;
                        end else begin
                            r_ball_x <= w_nx;
                            r_ball_y <= w_ny;
                            r_dx     <= w_ndx;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ball_ctrl.sv
// Directed bench for ball_ctrl: serve hold, walls, paddle hits,
// misses, leaving play and asynchronous reset.
module tb_ball_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [9:0]  x = '0;
    logic [9:0]  y = '0;
    logic        clk_1ms = 1'b0;
    logic [1:0]  game_state = 2'b00;
    logic [9:0]  paddle1_y = 10'd300;
    logic [9:0]  paddle2_y = 10'd400;
    logic        ball_on;
    logic [23:0] rgb_ball;
    logic        point_p1;
    logic        point_p2;

    int errors = 0;
    int checks = 0;
    int n_p1 = 0;
    int n_p2 = 0;
    int n_both = 0;

    ball_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .x          (x),
        .y          (y),
        .clk_1ms    (clk_1ms),
        .game_state (game_state),
        .paddle1_y  (paddle1_y),
        .paddle2_y  (paddle2_y),
        .ball_on    (ball_on),
        .rgb_ball   (rgb_ball),
        .point_p1   (point_p1),
        .point_p2   (point_p2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (point_p1) n_p1++;
        if (point_p2) n_p2++;
        if (point_p1 && point_p2) n_both++;
    end

    // n full motion steps: 5 clk_1ms rising edges each
    task automatic steps(input int n);
        for (int i = 0; i < n * 5; i++) begin
            @(negedge clk);
            clk_1ms = 1'b1;
            repeat (3) @(negedge clk);
            clk_1ms = 1'b0;
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic probe(input int px, input int py, output logic on);
        x = 10'(px);
        y = 10'(py);
        #1;
        on = ball_on;
    endtask

    // Returns {in(ex,ey), in(ex+7,ey+7), in(ex-1,ey), in(ex,ey-1),
    // in(ex+8,ey), in(ex,ey+8)}; a ball exactly at (ex,ey) gives 110000.
    task automatic pos_vec(input int ex, input int ey, output logic [5:0] v);
        probe(ex, ey, v[5]);
        probe(ex + 7, ey + 7, v[4]);
        probe(ex - 1, ey, v[3]);
        probe(ex, ey - 1, v[2]);
        probe(ex + 8, ey, v[1]);
        probe(ex, ey + 8, v[0]);
    endtask

    task automatic test_reset;
        logic on;
        logic [5:0] v;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        pos_vec(316, 236, v);
        checks++;
        if (v !== 6'b110000) begin
            errors++;
            $display("FAIL reset_pos: probes=%b want=110000", v);
        end
        checks++;
        if (rgb_ball !== 24'hFFFFFF) begin
            errors++;
            $display("FAIL rgb: got=%h want=FFFFFF", rgb_ball);
        end
        checks++;
        if (point_p1 !== 1'b0 || point_p2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_points: got=%b%b want=00", point_p1, point_p2);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        probe(316, 236, on);
        checks++;
        if (on !== 1'b1) begin
            errors++;
            $display("FAIL ball_on_in: got=%b want=1", on);
        end
        probe(315, 236, on);
        checks++;
        if (on !== 1'b0) begin
            errors++;
            $display("FAIL ball_on_out: got=%b want=0", on);
        end
    endtask

    task automatic test_idle_hold;
        logic [5:0] v;
        steps(4);
        pos_vec(316, 236, v);
        checks++;
        if (v !== 6'b110000) begin
            errors++;
            $display("FAIL idle_hold: probes=%b want=110000", v);
        end
    endtask

    task automatic test_serve;
        logic [5:0] v;
        @(negedge clk);
        game_state = 2'b01;
        steps(50);
        pos_vec(316, 236, v);
        checks++;
        if (v !== 6'b110000) begin
            errors++;
            $display("FAIL serve_hold: probes=%b want=110000", v);
        end
        steps(1);
        pos_vec(318, 238, v);
        checks++;
        if (v !== 6'b110000) begin
            errors++;
            $display("FAIL first_move: probes=%b want=110000", v);
        end
    endtask

    task automatic test_bottom_wall;
        logic [5:0] v;
        steps(117);
        pos_vec(552, 472, v);
        checks++;
        if (v !== 6'b110000) begin
            errors++;
            $display("FAIL bottom_reach: probes=%b want=110000", v);
        end
        steps(1);
        pos_vec(554, 472, v);
        checks++;
        if (v !== 6'b110000) begin
            errors++;
            $display("FAIL bottom_clamp: probes=%b want=110000", v);
        end
        steps(1);
        pos_vec(556, 470, v);
        checks++;
        if (v !== 6'b110000) begin
            errors++;
            $display("FAIL bottom_up: probes=%b want=110000", v);
        end
    endtask

    task automatic test_right_hit;
        logic [5:0] v;
        steps(17);
        pos_vec(590, 436, v);
        checks++;
        if (v !== 6'b110000) begin
            errors++;
            $display("FAIL right_pre: probes=%b want=110000", v);
        end
        steps(1);
        pos_vec(592, 434, v);
        checks++;
        if (v !== 6'b110000) begin
            errors++;
            $display("FAIL right_hit: probes=%b want=110000", v);
        end
        steps(1);
        pos_vec(590, 432, v);
        checks++;
        if (v !== 6'b110000) begin
            errors++;
            $display("FAIL right_back: probes=%b want=110000", v);
        end
        checks++;
        if (n_p1 != 0 || n_p2 != 0) begin
            errors++;
            $display("FAIL right_nopt: p1=%0d p2=%0d want=0 0", n_p1, n_p2);
        end
    endtask

    task automatic test_top_wall;
        logic [5:0] v;
        steps(216);
        pos_vec(158, 0, v);
        checks++;
        if (v !== 6'b110000) begin
            errors++;
            $display("FAIL top_reach: probes=%b want=110000", v);
        end
        steps(1);
        pos_vec(156, 0, v);
        checks++;
        if (v !== 6'b110000) begin
            errors++;
            $display("FAIL top_clamp: probes=%b want=110000", v);
        end
        steps(1);
        pos_vec(154, 2, v);
        checks++;
        if (v !== 6'b110000) begin
            errors++;
            $display("FAIL top_down: probes=%b want=110000", v);
        end
    endtask

    task automatic test_left_miss;
        logic [5:0] v;
        steps(77);
        pos_vec(0, 156, v);
        checks++;
        if (v !== 6'b110000) begin
            errors++;
            $display("FAIL miss_edge: probes=%b want=110000", v);
        end
        checks++;
        if (n_p2 != 0) begin
            errors++;
            $display("FAIL miss_early: p2=%0d want=0", n_p2);
        end
        steps(1);
        pos_vec(316, 236, v);
        checks++;
        if (v !== 6'b110000) begin
            errors++;
            $display("FAIL miss_centre: probes=%b want=110000", v);
        end
        checks++;
        if (n_p2 != 1 || n_p1 != 0) begin
            errors++;
            $display("FAIL miss_pulse: p1=%0d p2=%0d want=0 1", n_p1, n_p2);
        end
        steps(50);
        pos_vec(316, 236, v);
        checks++;
        if (v !== 6'b110000) begin
            errors++;
            $display("FAIL reserve_hold: probes=%b want=110000", v);
        end
        steps(1);
        pos_vec(314, 238, v);
        checks++;
        if (v !== 6'b110000) begin
            errors++;
            $display("FAIL reserve_dir: probes=%b want=110000", v);
        end
    endtask

    task automatic test_left_hit;
        logic [5:0] v;
        paddle1_y = 10'd400;
        steps(136);
        pos_vec(42, 436, v);
        checks++;
        if (v !== 6'b110000) begin
            errors++;
            $display("FAIL left_pre: probes=%b want=110000", v);
        end
        steps(1);
        pos_vec(40, 434, v);
        checks++;
        if (v !== 6'b110000) begin
            errors++;
            $display("FAIL left_hit: probes=%b want=110000", v);
        end
        steps(1);
        pos_vec(42, 432, v);
        checks++;
        if (v !== 6'b110000) begin
            errors++;
            $display("FAIL left_back: probes=%b want=110000", v);
        end
        checks++;
        if (n_p2 != 1 || n_p1 != 0) begin
            errors++;
            $display("FAIL left_nopt: p1=%0d p2=%0d want=0 1", n_p1, n_p2);
        end
    endtask

    task automatic test_stop_play;
        logic [5:0] v;
        @(negedge clk);
        game_state = 2'b00;
        repeat (2) @(negedge clk);
        pos_vec(316, 236, v);
        checks++;
        if (v !== 6'b110000) begin
            errors++;
            $display("FAIL stop_centre: probes=%b want=110000", v);
        end
        steps(5);
        pos_vec(316, 236, v);
        checks++;
        if (v !== 6'b110000) begin
            errors++;
            $display("FAIL stop_hold: probes=%b want=110000", v);
        end
        @(negedge clk);
        game_state = 2'b01;
        steps(51);
        pos_vec(318, 234, v);
        checks++;
        if (v !== 6'b110000) begin
            errors++;
            $display("FAIL replay_dir: probes=%b want=110000", v);
        end
    endtask

    task automatic test_reset_mid_move;
        logic [5:0] v;
        @(negedge clk);
        #2;
        reset = 1'b0;
        pos_vec(316, 236, v);
        checks++;
        if (v !== 6'b110000) begin
            errors++;
            $display("FAIL async_reset: probes=%b want=110000", v);
        end
        checks++;
        if (point_p1 !== 1'b0 || point_p2 !== 1'b0) begin
            errors++;
            $display("FAIL rst_points: got=%b%b want=00", point_p1, point_p2);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (n_p1 != 0 || n_p2 != 1 || n_both != 0) begin
            errors++;
            $display("FAIL pulse_total: p1=%0d p2=%0d both=%0d want=0 1 0",
                     n_p1, n_p2, n_both);
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_idle_hold();
        test_serve();
        test_bottom_wall();
        test_right_hit();
        test_top_wall();
        test_left_miss();
        test_left_hit();
        test_stop_play();
        test_reset_mid_move();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
